// File: rtl/dt_res_sched.sv
// rtl/dt_res_sched.sv - forward/backward pass sequencer and result-memory arbiter
module dt_res_sched #(
  parameter logic [1:0] HS_MAXWAIT = 2'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        fw_start,
  output logic        bw_start,
  input  logic        fw_done,
  input  logic        bw_done,
  input  logic        fw_req,
  input  logic        bw_req,
  input  logic        hs_req,
  input  logic        fw_we,
  input  logic        bw_we,
  input  logic        hs_we,
  input  logic [13:0] fw_addr,
  input  logic [13:0] bw_addr,
  input  logic [13:0] hs_addr,
  input  logic [7:0]  fw_wdata,
  input  logic [7:0]  bw_wdata,
  input  logic [7:0]  hs_wdata,
  output logic        fw_gnt,
  output logic        bw_gnt,
  output logic        hs_gnt,
  output logic        fw_rvalid,
  output logic        bw_rvalid,
  output logic        hs_rvalid,
  output logic [7:0]  rdata,
  output logic        res_rd,
  output logic        res_wr,
  output logic [13:0] res_addr,
  output logic [7:0]  res_do,
  input  logic [7:0]  res_di
);

  typedef enum logic [2:0] {
    S_IDLE, S_FW, S_FW_DRAIN, S_BW, S_BW_DRAIN, S_DONE
  } state_t;

  typedef enum logic [1:0] {
    TAG_NONE, TAG_FW, TAG_BW, TAG_HS
  } tag_t;

  state_t      r_state;
  logic [1:0]  r_hs_wait;
  tag_t        r_tag1;
  tag_t        r_tag2;
  logic        r_busy;
  logic        r_done;
  logic        r_fw_start;
  logic        r_bw_start;
  logic        r_res_rd;
  logic        r_res_wr;
  logic [13:0] r_res_addr;
  logic [7:0]  r_res_do;

  logic        w_hs_urgent;
  logic        w_fw_gnt;
  logic        w_bw_gnt;
  logic        w_hs_gnt;
  logic        w_any_gnt;
  logic        w_we;
  logic [13:0] w_addr;
  logic [7:0]  w_wdata;
  tag_t        w_rd_tag;
  logic        w_drained;

  // The host has waited long enough and takes this one cycle from the engine.
  assign w_hs_urgent = hs_req && (r_hs_wait == HS_MAXWAIT);

  // Engines are granted only in their own pass; grants are masked while reset is held.
  assign w_fw_gnt = reset && (r_state == S_FW) && fw_req && !w_hs_urgent;
  assign w_bw_gnt = reset && (r_state == S_BW) && bw_req && !w_hs_urgent;

  // Host grant: yields to the owning engine during a pass unless it is urgent.
  always_comb begin
    w_hs_gnt = 1'b0;
    if (reset && hs_req) begin
      case (r_state)
        S_FW:    w_hs_gnt = !fw_req || w_hs_urgent;
        S_BW:    w_hs_gnt = !bw_req || w_hs_urgent;
        default: w_hs_gnt = 1'b1;
      endcase
    end
  end

  assign w_any_gnt = w_fw_gnt || w_bw_gnt || w_hs_gnt;

  // Select the granted requester's access onto the memory side.
  always_comb begin
    w_we     = hs_we;
    w_addr   = hs_addr;
    w_wdata  = hs_wdata;
    w_rd_tag = TAG_NONE;
    if (w_fw_gnt) begin
      w_we    = fw_we;
      w_addr  = fw_addr;
      w_wdata = fw_wdata;
      if (!fw_we) w_rd_tag = TAG_FW;
    end else if (w_bw_gnt) begin
      w_we    = bw_we;
      w_addr  = bw_addr;
      w_wdata = bw_wdata;
      if (!bw_we) w_rd_tag = TAG_BW;
    end else if (w_hs_gnt && !hs_we) begin
      w_rd_tag = TAG_HS;
    end
  end

  // A read in stage 2 returns this cycle, so only stage 1 still holds the phase open.
  assign w_drained = (r_tag1 == TAG_NONE);

  // Pass sequencing with registered start/busy/done outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_fw_start <= 1'b0;
      r_bw_start <= 1'b0;
    end else begin
      r_fw_start <= 1'b0;
      r_bw_start <= 1'b0;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_state    <= S_FW;
            r_fw_start <= 1'b1;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_FW: begin
          if (fw_done) r_state <= S_FW_DRAIN;
        end
        S_FW_DRAIN: begin
          if (w_drained) begin
            r_state    <= S_BW;
            r_bw_start <= 1'b1;
          end
        end
        S_BW: begin
          if (bw_done) r_state <= S_BW_DRAIN;
        end
        S_BW_DRAIN: begin
          if (w_drained) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Count consecutive denied host cycles, saturating at the urgency threshold.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hs_wait <= 2'd0;
    end else if (!hs_req || w_hs_gnt) begin
      r_hs_wait <= 2'd0;
    end else if (r_hs_wait != HS_MAXWAIT) begin
      r_hs_wait <= r_hs_wait + 2'd1;
    end
  end

  // Register the granted access onto the memory bus and shift the read-owner tags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_rd   <= 1'b0;
      r_res_wr   <= 1'b0;
      r_res_addr <= 14'd0;
      r_res_do   <= 8'd0;
      r_tag1     <= TAG_NONE;
      r_tag2     <= TAG_NONE;
    end else begin
      r_res_rd <= w_any_gnt && !w_we;
      r_res_wr <= w_any_gnt && w_we;
      if (w_any_gnt) begin
        r_res_addr <= w_addr;
        r_res_do   <= w_wdata;
      end
      r_tag1 <= w_rd_tag;
      r_tag2 <= r_tag1;
    end
  end

  assign fw_gnt    = w_fw_gnt;
  assign bw_gnt    = w_bw_gnt;
  assign hs_gnt    = w_hs_gnt;
  assign fw_rvalid = (r_tag2 == TAG_FW);
  assign bw_rvalid = (r_tag2 == TAG_BW);
  assign hs_rvalid = (r_tag2 == TAG_HS);
  assign rdata     = res_di;
  assign busy      = r_busy;
  assign done      = r_done;
  assign fw_start  = r_fw_start;
  assign bw_start  = r_bw_start;
  assign res_rd    = r_res_rd;
  assign res_wr    = r_res_wr;
  assign res_addr  = r_res_addr;
  assign res_do    = r_res_do;

endmodule
